// File: rtl/booth_r4_mult_16bit.sv
// Sequential unsigned 16x16 radix-4 Booth multiplier, one digit retired per clock.
// Define EARLY_TERM_EN to finish as soon as all remaining Booth digits are zero.
module booth_r4_mult_16bit #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int NDIG = (W + 2) / 2;
  localparam int YW   = W + 2;
  localparam int AW   = 2 * W + 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [W-1:0]         a_reg;
  logic [YW-1:0]        y_reg;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic [3:0]           cnt;
  logic [YW:0]          y_ext;
  logic [2:0]           trip;
  logic                 accept;
  logic                 last_dig;

  // Partial product for one digit: {0,+-A,+-2A} weighted by 4^idx.
  function automatic logic signed [AW-1:0] booth_pp(input logic [2:0]   t,
                                                    input logic [W-1:0] a,
                                                    input logic [3:0]   idx);
    logic signed [AW-1:0] a_ext;
    logic signed [AW-1:0] mag;
    a_ext = {{(AW-W){1'b0}}, a};
    mag   = '0;
    case (t)
      3'b001, 3'b010: mag = a_ext;
      3'b011:         mag = a_ext <<< 1;
      3'b100:         mag = -(a_ext <<< 1);
      3'b101, 3'b110: mag = -a_ext;
      default:        mag = '0;
    endcase
    return mag <<< {idx, 1'b0};
  endfunction

  assign y_ext   = {y_reg, 1'b0};
  assign trip    = y_ext[{cnt, 1'b0} +: 3];
  assign acc_nxt = acc + booth_pp(trip, a_reg, cnt);

`ifdef EARLY_TERM_EN
  logic rest_zero;
  // Once y[17:2i+1] is clear every later digit is zero, so the sum is final.
  assign rest_zero = ((y_reg >> ({cnt, 1'b0} + 5'd1)) == '0);
  assign last_dig  = (cnt == 4'(NDIG - 1)) || rest_zero;
`else
  assign last_dig  = (cnt == 4'(NDIG - 1));
`endif

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_dig) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + 4'd1;
        if (last_dig) product <= acc_nxt[2*W-1:0];
      end
    end
  end

  // Operand registers are pure data and only load on an accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= multiplicand;
      y_reg <= {2'b00, multiplier};
    end
  end

endmodule

// File: tb/tb_booth_r4_mult_16bit.sv
// Self-checking bench for booth_r4_mult_16bit: timeline model plus directed literal vectors.
// Honours EARLY_TERM_EN for the expected latency.
module tb_booth_r4_mult_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

`ifdef EARLY_TERM_EN
  localparam int L0 = 1, L3 = 2, LFF = 5, L101 = 5, T3C = 1;
`else
  localparam int L0 = 9, L3 = 9, LFF = 9, L101 = 9, T3C = 4;
`endif

  booth_r4_mult_16bit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input logic [15:0] b);
`ifdef EARLY_TERM_EN
    logic [18:0] y;
    int d;
    int last;
    y = {2'b00, b, 1'b0};
    last = 0;
    for (int i = 0; i < 9; i++) begin
      d = -2 * int'(y[2*i+2]) + int'(y[2*i+1]) + int'(y[2*i]);
      if (d != 0) last = i;
    end
    return last + 1;
`else
    return 9;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Timeline model: an accepted request finishes lat_of(B) edges later with A*B.
  logic        m_run = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_left <= 0;
    end else if (m_run) begin
      if (m_left == 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_a * m_b;
      end
      m_left <= m_left - 1;
    end else if (start) begin
      m_a    <= {16'h0, multiplicand};
      m_b    <= {16'h0, multiplier};
      m_run  <= 1'b1;
      m_left <= lat_of(multiplier);
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'h0, busy}, {31'h0, m_run});
      check("done", {31'h0, done}, {31'h0, m_done});
      check("product", product, m_prod);
      if (done) check("acc_hi", {29'h0, dut.acc[34:32]}, 32'h0);
    end
  end

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int already, output int lat);
    lat = 0;
    for (int k = already + 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_prod, input int exp_lat);
    int lat;
    pulse_start(a, b);
    wait_done(0, lat);
    check({name, "_prod"}, product, exp_prod);
    if (exp_lat != 0) check({name, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_product", product, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // T1
    pulse_start(16'd5, 16'd3);
    check("t1_busy", {31'h0, busy}, 32'h1);
    wait_done(0, lat);
    check("t1_prod", product, 32'h0000000F);
    check("t1_lat", lat, L3);
    @(posedge clk); #1;
    check("t1_done_low", {31'h0, done}, 32'h0);

    // T2 and boundary operands
    run_op("t2_max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 9);
    run_op("t2_b0", 16'h1234, 16'h0000, 32'h0, L0);
    run_op("t2_b8000", 16'h1234, 16'h8000, 32'h091A0000, 9);
    run_op("t2_a8000", 16'h8000, 16'h0003, 32'h00018000, L3);
    run_op("t2_bff", 16'h0101, 16'h00FF, 32'h0000FFFF, LFF);
    run_op("t2_a0", 16'h0000, 16'hFFFF, 32'h0, 9);

    // T3: start during CALC is ignored
    pulse_start(16'd2, 16'd3);
    repeat (T3C - 1) @(posedge clk);
    #1;
    start = 1'b1;
    multiplicand = 16'd7;
    multiplier = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(T3C, lat);
    check("t3_prod", product, 32'h6);
    check("t3_lat", lat, L3);
    @(posedge clk); #1;

    // T4: reset mid-CALC
    pulse_start(16'h1111, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t4_busy", {31'h0, busy}, 32'h0);
    check("t4_done", {31'h0, done}, 32'h0);
    check("t4_product", product, 32'h0);
    run_op("t4_after", 16'h1234, 16'h5678, 32'h06260060, 0);

    // T5: back-to-back start from DONE
    pulse_start(16'd5, 16'd3);
    wait_done(0, lat);
    start = 1'b1;
    multiplicand = 16'h00FF;
    multiplier = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_busy", {31'h0, busy}, 32'h1);
    wait_done(0, lat);
    check("t5_prod", product, 32'h0000FFFF);
    check("t5_lat", lat, L101);
    @(posedge clk); #1;

    // T6: random pairs
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 16 == 0) rb = 16'($urandom_range(0, 15));
      pulse_start(ra, rb);
      wait_done(0, lat);
      check("t6_prod", product, {16'h0, ra} * {16'h0, rb});
      check("t6_lat", lat, lat_of(rb));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
